// File: rtl/module_teclado_scanner.sv
// Active 4x4 keypad scanner: walks a single low row across the matrix, debounces the
// synchronized column lines and emits one key-code strobe per accepted press.
module module_teclado_scanner #(
    parameter int ROW_DWELL        = 27000,
    parameter int DEBOUNCE_SAMPLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] column,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DWELL_W = $clog2(ROW_DWELL);
    localparam int DEB_W   = $clog2(DEBOUNCE_SAMPLES + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROW_DWELL - 1);
    localparam logic [DEB_W-1:0]   DEB_TARGET = DEB_W'(DEBOUNCE_SAMPLES);
    localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(1);
    localparam logic [3:0]         NO_KEY     = 4'b1111;

    localparam logic [1:0] SCAN      = 2'd0;
    localparam logic [1:0] PRESS_DEB = 2'd1;
    localparam logic [1:0] HELD      = 2'd2;

    logic [3:0]         col_meta;
    logic [3:0]         col_s;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DEB_W-1:0]   deb_cnt;
    logic [DEB_W-1:0]   deb_inc;
    logic [1:0]         state;
    logic [1:0]         row_idx;
    logic [3:0]         key_pat;
    logic               sample;

    // A pattern is a key only when exactly one column is pulled low.
    function automatic logic single_low(input logic [3:0] pat);
        case (pat)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
            default:                            single_low = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] pat);
        case (pat)
            4'b1101: col_index = 2'd1;
            4'b1011: col_index = 2'd2;
            4'b0111: col_index = 2'd3;
            default: col_index = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: map_key = 4'h1;
            4'b00_01: map_key = 4'h2;
            4'b00_10: map_key = 4'h3;
            4'b00_11: map_key = 4'hA;
            4'b01_00: map_key = 4'h4;
            4'b01_01: map_key = 4'h5;
            4'b01_10: map_key = 4'h6;
            4'b01_11: map_key = 4'hB;
            4'b10_00: map_key = 4'h7;
            4'b10_01: map_key = 4'h8;
            4'b10_10: map_key = 4'h9;
            4'b10_11: map_key = 4'hC;
            4'b11_00: map_key = 4'hE;
            4'b11_01: map_key = 4'h0;
            4'b11_10: map_key = 4'hF;
            default:  map_key = 4'hD;
        endcase
    endfunction

    assign sample  = (dwell_cnt == DWELL_LAST);
    assign deb_inc = deb_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta  <= NO_KEY;
            col_s     <= NO_KEY;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            state     <= SCAN;
            row       <= 4'b1110;
            row_idx   <= 2'd0;
            key_pat   <= NO_KEY;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            // Two-flop synchronizer: the keypad pins are asynchronous to clk.
            col_meta  <= column;
            col_s     <= col_meta;
            dwell_cnt <= sample ? '0 : dwell_cnt + 1'b1;
            key_valid <= 1'b0;

            if (sample) begin
                case (state)
                    SCAN: begin
                        if (single_low(col_s)) begin
                            key_pat <= col_s;
                            if (DEBOUNCE_SAMPLES == 1) begin
                                key_code  <= map_key(row_idx, col_index(col_s));
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                deb_cnt <= DEB_ONE;
                                state   <= PRESS_DEB;
                            end
                        end else begin
                            row     <= {row[2:0], row[3]};
                            row_idx <= row_idx + 2'd1;
                        end
                    end

                    PRESS_DEB: begin
                        if (col_s == key_pat) begin
                            if (deb_inc == DEB_TARGET) begin
                                key_code  <= map_key(row_idx, col_index(key_pat));
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                deb_cnt <= deb_inc;
                            end
                        end else begin
                            deb_cnt <= '0;
                            state   <= SCAN;
                            row     <= {row[2:0], row[3]};
                            row_idx <= row_idx + 2'd1;
                        end
                    end

                    HELD: begin
                        // Only an all-high sample counts toward release; anything else restarts it.
                        if (col_s == NO_KEY) begin
                            if (deb_inc == DEB_TARGET) begin
                                key_held <= 1'b0;
                                deb_cnt  <= '0;
                                state    <= SCAN;
                                row      <= {row[2:0], row[3]};
                                row_idx  <= row_idx + 2'd1;
                            end else begin
                                deb_cnt <= deb_inc;
                            end
                        end else begin
                            deb_cnt <= '0;
                        end
                    end

                    default: begin
                        deb_cnt <= '0;
                        state   <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_module_teclado_scanner.sv
// Bench for module_teclado_scanner: keypad matrix model, sample-level behavioural
// reference checked every cycle, plus directed key scenarios with literal expectations.
`timescale 1ns/1ps
module tb_module_teclado_scanner;

    localparam int RD = 4;
    localparam int DS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] column;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [15:0] pressed = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    module_teclado_scanner #(.ROW_DWELL(RD), .DEBOUNCE_SAMPLES(DS)) dut (
        .clk      (clk),
        .rst      (rst),
        .column   (column),
        .row      (row),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Keypad: column c is pulled low when key (r,c) is pressed and row r is driven low.
    always_comb begin
        column = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && (row[r] == 1'b0)) column[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural reference, one step per clock edge.
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};
    logic [3:0] m_s1, m_s2, m_pat, m_code;
    int         m_cnt, m_row, m_mode, m_n, m_first_cyc;
    logic       m_valid, m_held;
    bit         m_init = 1'b0;

    function automatic int zeros(input logic [3:0] p);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!p[i]) n++;
        return n;
    endfunction

    function automatic int low_idx(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (!p[i]) return i;
        return 0;
    endfunction

    task automatic m_accept();
        m_code  = keymap[m_row*4 + low_idx(m_pat)];
        m_valid = 1'b1;
        m_held  = 1'b1;
        m_mode  = 2;
        m_n     = 0;
    endtask

    task automatic model_step();
        logic [3:0] smp;
        cyc++;
        if (rst) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_pat = 4'hF; m_code = 4'h0;
            m_cnt = 0; m_row = 0; m_mode = 0; m_n = 0;
            m_valid = 1'b0; m_held = 1'b0; m_init = 1'b1;
        end else begin
            smp  = m_s2;
            m_s2 = m_s1;
            m_s1 = column;
            m_valid = 1'b0;
            if (m_cnt == RD-1) begin
                if (m_mode == 0) begin
                    if (zeros(smp) == 1) begin
                        m_pat = smp; m_n = 1; m_first_cyc = cyc - 1;
                        if (m_n == DS) m_accept(); else m_mode = 1;
                    end else m_row = (m_row + 1) % 4;
                end else if (m_mode == 1) begin
                    if (smp == m_pat) begin
                        m_n++;
                        if (m_n == DS) m_accept();
                    end else begin
                        m_mode = 0; m_n = 0; m_row = (m_row + 1) % 4;
                    end
                end else begin
                    if (smp == 4'hF) begin
                        m_n++;
                        if (m_n == DS) begin
                            m_held = 1'b0; m_mode = 0; m_n = 0; m_row = (m_row + 1) % 4;
                        end
                    end else m_n = 0;
                end
            end
            m_cnt = (m_cnt + 1) % RD;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare against the reference, plus strobe/row-change bookkeeping.
    int         n_strobe = 0;
    int         n_rowchg = 0;
    int         strobe_cyc = 0;
    logic [3:0] last_code = 4'h0;
    logic [3:0] prev_row  = 4'b1110;

    initial forever begin
        logic [3:0] er;
        @(negedge clk);
        if (m_init) begin
            er = ~(4'b0001 << m_row);
            check("row", 32'(row), 32'(er));
            check("key_valid", 32'(key_valid), 32'(m_valid));
            check("key_held", 32'(key_held), 32'(m_held));
            check("key_code", 32'(key_code), 32'(m_code));
            if (key_valid === 1'b1) begin
                n_strobe++;
                last_code  = key_code;
                strobe_cyc = cyc;
            end
            if (row !== prev_row) n_rowchg++;
            prev_row = row;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_strobe(input int base);
        int k = 0;
        while (n_strobe == base && k < 400) begin step(); k++; end
    endtask

    task automatic wait_released();
        int k = 0;
        while (key_held !== 1'b0 && k < 400) begin step(); k++; end
    endtask

    task automatic wait_deb2();
        int k = 0;
        while (!(m_mode == 1 && m_n == 2) && k < 400) begin step(); k++; end
    endtask

    task automatic press_key(input int r, input int c, input logic [3:0] code,
                             input logic [3:0] next_row, input string name);
        int base;
        base = n_strobe;
        pressed[r*4+c] = 1'b1;
        wait_strobe(base);
        check({name, "_code"}, 32'(last_code), 32'(code));
        repeat (20*RD) step();
        check({name, "_strobes"}, n_strobe - base, 1);
        check({name, "_held"}, 32'(key_held), 1);
        pressed[r*4+c] = 1'b0;
        wait_released();
        check({name, "_released"}, 32'(key_held), 0);
        check({name, "_resume_row"}, 32'(row), 32'(next_row));
        repeat (8) step();
    endtask

    initial begin
        logic [3:0] seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        int base;
        int rc;

        // 1: reset state and free-running scan
        repeat (3) step();
        check("rst_row", 32'(row), 32'(4'b1110));
        check("rst_code", 32'(key_code), 0);
        check("rst_valid", 32'(key_valid), 0);
        check("rst_held", 32'(key_held), 0);
        rst = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            step();
            check("scan_seq", 32'(row), 32'(seq[(j/4)%4]));
        end
        check("t1_no_strobe", n_strobe, 0);

        // 2: key "2", strobe latency and resume at row 1
        base = n_strobe;
        pressed[1] = 1'b1;
        wait_strobe(base);
        check("t2_code", 32'(last_code), 32'(4'h2));
        check("t2_latency", strobe_cyc - m_first_cyc, (DS-1)*RD + 1);
        repeat (20*RD) step();
        check("t2_strobes", n_strobe - base, 1);
        check("t2_held", 32'(key_held), 1);
        pressed[1] = 1'b0;
        wait_released();
        check("t2_released", 32'(key_held), 0);
        check("t2_resume_row", 32'(row), 32'(4'b1101));
        repeat (8) step();

        // 3: bottom-row keys
        press_key(3, 2, 4'hF, 4'b1110, "t3_hash");
        press_key(3, 3, 4'hD, 4'b1110, "t3_d");
        press_key(3, 1, 4'h0, 4'b1110, "t3_zero");

        // 5: ghosting on row 0 is no key and never stalls the scan
        base = n_strobe;
        rc   = n_rowchg;
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        repeat (25*RD) step();
        check("t5_rowchg", n_rowchg - rc, 25);
        check("t5_strobes", n_strobe - base, 0);
        check("t5_held", 32'(key_held), 0);
        pressed[0] = 1'b0;
        pressed[1] = 1'b0;
        repeat (8) step();

        // 4: bounce on key "5"
        base = n_strobe;
        pressed[5] = 1'b1;
        wait_deb2();
        pressed[5] = 1'b0;
        begin
            int k = 0;
            while (m_mode != 0 && k < 100) begin step(); k++; end
        end
        check("t4_discard_strobes", n_strobe - base, 0);
        check("t4_discard_row", 32'(row), 32'(4'b1011));
        pressed[5] = 1'b1;
        wait_strobe(base);
        check("t4_code", 32'(last_code), 32'(4'h5));
        repeat (4*RD) step();
        check("t4_strobes", n_strobe - base, 1);
        pressed[5] = 1'b0;
        wait_released();
        repeat (8) step();

        // 6: reset during press debounce
        base = n_strobe;
        pressed[5] = 1'b1;
        wait_deb2();
        rst = 1'b1;
        step();
        check("t6_valid", 32'(key_valid), 0);
        check("t6_row", 32'(row), 32'(4'b1110));
        check("t6_held", 32'(key_held), 0);
        check("t6_code", 32'(key_code), 0);
        pressed[5] = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        repeat (10*RD) step();
        check("t6_strobes", n_strobe - base, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/module_teclado_scanner.md
Name: module_teclado_scanner

Overview:
Active scanner for the 4x4 matrix keypad, paired with module_teclado_detector.
- Drives the row lines active-low, one row at a time, and samples the pulled-up column lines.
- Debounces press and release, then emits one key-code strobe per press for downstream logic.
- Runs on the board clock (27 MHz); the keypad pins are asynchronous to it.

Parameters:
- ROW_DWELL, 27000: clk cycles each row is driven low (1 ms at 27 MHz); minimum legal value 4.
- DEBOUNCE_SAMPLES, 8: consecutive identical column samples required to accept a press, and also to accept a release; minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- column  input  4  keypad columns, active-low, asynchronous; bit0 = column 0
- row  output  4  keypad rows, active-low, exactly one bit low at all times; bit0 = row 0
- key_code  output  4  code of last accepted key, held until the next accepted key
- key_valid  output  1  one-cycle strobe, high in the cycle key_code updates
- key_held  output  1  high from the accepted press until the accepted release

Behaviour:
Reset values:
- row = 4'b1110, key_code = 4'h0, key_valid = 0, key_held = 0.
- FSM in SCAN; dwell counter, debounce counter and synchronizer flops cleared (synchronizer flops reset to 4'b1111).
- Reset mid-press: no key_valid, key_held drops, scanning restarts at row 0.

Synchronizer:
- column passes through 2 flops before any use. Call the synchronized value col_s.

Sample point:
- The dwell counter counts 0..ROW_DWELL-1 for every row.
- col_s is sampled only on the cycle where the count is ROW_DWELL-1; this is one "sample".
- The counter wraps to 0 after ROW_DWELL-1 in every state.

Valid pattern:
- A sample is a valid key only if col_s has exactly one bit at 0.
- 4'b1111 means no key. Two or more low bits (ghosting or multi-press) are treated as no key.

Key map (row, column index -> code):
- Row 0: 0 -> 1, 1 -> 2, 2 -> 3, 3 -> A
- Row 1: 0 -> 4, 1 -> 5, 2 -> 6, 3 -> B
- Row 2: 0 -> 7, 1 -> 8, 2 -> 9, 3 -> C
- Row 3: 0 -> E (*), 1 -> 0, 2 -> F (#), 3 -> D

FSM states:
- SCAN:
  - At each sample with no valid key, row rotates left (1110 -> 1101 -> 1011 -> 0111 -> 1110) in the cycle after the sample.
  - On a valid key: latch row index and col_s pattern, deb_cnt = 1. Row does NOT advance.
  - If DEBOUNCE_SAMPLES == 1, go straight to the PRESS_DEB acceptance action; otherwise go to PRESS_DEB.
- PRESS_DEB (row held):
  - Sample equals latched pattern: deb_cnt++.
  - When deb_cnt reaches DEBOUNCE_SAMPLES: on the next cycle key_code = mapped code, key_valid = 1 for exactly one cycle, key_held = 1, go to HELD.
  - Sample differs: press discarded, no strobe, return to SCAN, row advances.
- HELD (row held):
  - A sample of 4'b1111 starts/continues the release count; any other sample resets the count to 0.
  - Changing to another key on the same row without a full release emits nothing.
  - After DEBOUNCE_SAMPLES consecutive 4'b1111 samples: key_held = 0, go to SCAN, row advances.

Latency:
- First valid sample to key_valid is (DEBOUNCE_SAMPLES-1)*ROW_DWELL + 1 cycles.

Boundary cases:
- A held key never re-strobes (no auto-repeat).
- Keys on other rows are invisible while in HELD.
- The dwell counter never stalls.

Test Plan:
Bench parameters: ROW_DWELL=4, DEBOUNCE_SAMPLES=3. The bench models the keypad: column bit c = 0 iff key (r, c) is pressed and row bit r = 0.

1. Reset, no key:
   - Stimulus: reset, release with no key pressed.
   - Required: row sequence 1110,1101,1011,0111,1110 at 4-cycle steps; key_valid never 1; key_held = 0.
2. Press key "2" (row 0, col 1) for 20 samples, then release:
   - Required: exactly one key_valid pulse with key_code = 4'h2, 2*4+1 = 9 cycles after the first valid sample.
   - Required: key_held = 1 until 3 release samples, then scanning resumes at row 1101.
3. Press "#" (row 3, col 2):
   - Required: key_code = 4'hF.
   - Then press "D" (row 3, col 3): key_code = 4'hD.
   - Then press "0" (row 3, col 1): key_code = 4'h0.
   - Each key produces exactly one strobe.
4. Bounce:
   - Stimulus: key "5" present for 2 samples, absent for 1, then stable.
   - Required: first attempt discarded with no strobe; single strobe with key_code = 4'h5 after 3 stable samples.
5. Ghost:
   - Stimulus: keys "1" and "2" pressed together (row 0 gives column = 1100).
   - Required: no strobe; row keeps rotating.
6. Reset mid-press:
   - Stimulus: rst asserted while in PRESS_DEB (deb_cnt = 2).
   - Required: no key_valid, row = 1110, key_held = 0, key_code = 4'h0.
